// File: rtl/xpe_accum_threshold_if.sv
// Handshake/data bundle between the popcount PE, the accumulator and its consumer.
interface xpe_accum_threshold_if #(
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned WORDS_MAX = 64
);
    localparam int unsigned PCW   = $clog2(WORD_SIZE + 1);
    localparam int unsigned NWW   = $clog2(WORDS_MAX + 1);
    localparam int unsigned ACC_W = $clog2(WORD_SIZE * WORDS_MAX + 1);

    logic [NWW-1:0]   cfg_num_words;
    logic [ACC_W-1:0] cfg_threshold;
    logic             in_valid;
    logic             in_ready;
    logic [PCW-1:0]   in_popcount;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_bit;
    logic [15:0]      neuron_count;

    modport master (
        output cfg_num_words, cfg_threshold, in_valid, in_popcount, out_ready,
        input  in_ready, out_valid, out_sum, out_bit, neuron_count
    );

    modport slave (
        input  cfg_num_words, cfg_threshold, in_valid, in_popcount, out_ready,
        output in_ready, out_valid, out_sum, out_bit, neuron_count
    );
endinterface

// File: rtl/xpe_accum_threshold.sv
// Accumulates per-word popcounts over one neuron's fan-in and binarises the
// total against a threshold latched on the neuron's first beat.
module xpe_accum_threshold #(
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned WORDS_MAX = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    xpe_accum_threshold_if.slave   bus
);
    localparam int unsigned NWW   = $clog2(WORDS_MAX + 1);
    localparam int unsigned ACC_W = $clog2(WORD_SIZE * WORDS_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [NWW-1:0]   cnt_q, cnt_d;
    logic [NWW-1:0]   num_q, num_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_bit_q, out_bit_d;
    logic [15:0]      count_q, count_d;

    logic             in_ready_c;
    logic             accept;
    logic             handoff;
    logic             first;
    logic             last;
    logic [NWW-1:0]   num_clamped;
    logic [NWW-1:0]   num_cur;
    logic [NWW-1:0]   cnt_cur;
    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] thr_cur;
    logic [ACC_W-1:0] sum;

    // Handshake decode; a beat seen outside ACCUM always starts a new neuron
    assign in_ready_c  = !rst && ((state_q != EMIT) || bus.out_ready);
    assign accept      = bus.in_valid && in_ready_c;
    assign handoff     = (state_q == EMIT) && bus.out_ready;
    assign first       = accept && (state_q != ACCUM);
    assign num_clamped = (bus.cfg_num_words == '0)               ? NWW'(1) :
                         (bus.cfg_num_words > NWW'(WORDS_MAX))   ? NWW'(WORDS_MAX) :
                                                                   bus.cfg_num_words;
    assign num_cur     = first ? num_clamped : num_q;
    assign thr_cur     = first ? bus.cfg_threshold : thr_q;
    assign cnt_cur     = first ? '0 : cnt_q;
    assign acc_cur     = first ? '0 : acc_q;
    assign sum         = acc_cur + ACC_W'(bus.in_popcount);
    assign last        = accept && (NWW'(cnt_cur + NWW'(1)) == num_cur);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: EMIT holds until hand-off; a beat in the hand-off cycle acts as an IDLE first beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = last ? EMIT : ACCUM;
            ACCUM:   if (last) state_d = EMIT;
            EMIT: begin
                if (handoff) begin
                    if (accept) state_d = last ? EMIT : ACCUM;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch config on first beat, accumulate, capture result on last beat
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        thr_d     = thr_q;
        out_sum_d = out_sum_q;
        out_bit_d = out_bit_q;
        count_d   = count_q + 16'(handoff);
        if (accept) begin
            num_d = num_cur;
            thr_d = thr_cur;
            if (last) begin
                acc_d     = '0;
                cnt_d     = '0;
                out_sum_d = sum;
                out_bit_d = (sum >= thr_cur);
            end else begin
                acc_d = sum;
                cnt_d = NWW'(cnt_cur + NWW'(1));
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            num_q     <= '0;
            thr_q     <= '0;
            out_sum_q <= '0;
            out_bit_q <= 1'b0;
            count_q   <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            thr_q     <= thr_d;
            out_sum_q <= out_sum_d;
            out_bit_q <= out_bit_d;
            count_q   <= count_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = (state_q == EMIT);
    assign bus.out_sum      = out_sum_q;
    assign bus.out_bit      = out_bit_q;
    assign bus.neuron_count = count_q;

endmodule

// File: tb/tb_xpe_accum_threshold.sv
// Directed and randomized checks of xpe_accum_threshold against a beat-list reference model.
module tb_xpe_accum_threshold;
    localparam int unsigned WORD_SIZE = 64;
    localparam int unsigned WORDS_MAX = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    xpe_accum_threshold_if #(.WORD_SIZE(WORD_SIZE), .WORDS_MAX(WORDS_MAX)) bus ();

    xpe_accum_threshold #(.WORD_SIZE(WORD_SIZE), .WORDS_MAX(WORDS_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the beats of the neuron in progress, plus the last emitted result
    int cfg_n = 1;
    int cfg_t = 0;
    int beats[$];
    int m_n = 1;
    int m_t = 0;
    bit m_valid = 1'b0;
    int m_sum = 0;
    bit m_bit = 1'b0;
    int m_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        beats.delete();
        m_valid = 1'b0;
        m_sum   = 0;
        m_bit   = 1'b0;
        m_count = 0;
    endtask

    // One clock: drive inputs, check at negedge, advance the model, then cross the edge
    task automatic cycle(input bit v, input int pc, input bit ordy);
        bit acc_m;
        bit hs_m;
        int s;
        bus.cfg_num_words = 7'(cfg_n);
        bus.cfg_threshold = 13'(cfg_t);
        bus.in_valid      = v;
        bus.in_popcount   = 7'(pc);
        bus.out_ready     = ordy;
        @(negedge clk);
        chk("in_ready",     32'(bus.in_ready),     32'(!m_valid || ordy));
        chk("out_valid",    32'(bus.out_valid),    32'(m_valid));
        chk("out_sum",      32'(bus.out_sum),      32'(m_sum));
        chk("out_bit",      32'(bus.out_bit),      32'(m_bit));
        chk("neuron_count", 32'(bus.neuron_count), 32'(m_count % 65536));
        hs_m  = m_valid && ordy;
        acc_m = v && (!m_valid || ordy);
        if (hs_m) begin
            m_count++;
            m_valid = 1'b0;
        end
        if (acc_m) begin
            if (beats.size() == 0) begin
                m_n = (cfg_n == 0) ? 1 : (cfg_n > int'(WORDS_MAX) ? int'(WORDS_MAX) : cfg_n);
                m_t = cfg_t;
            end
            beats.push_back(pc);
            if (beats.size() == m_n) begin
                s = 0;
                foreach (beats[i]) s += beats[i];
                m_sum   = s;
                m_bit   = (s >= m_t);
                m_valid = 1'b1;
                beats.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Synchronous reset with a beat offered; in_ready must stay low while rst is high
    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_popcount = 7'd5;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        chk("in_ready_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        bus.cfg_num_words = '0;
        bus.cfg_threshold = '0;
        bus.in_valid      = 1'b0;
        bus.in_popcount   = '0;
        bus.out_ready     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
        chk("rst_count",     32'(bus.neuron_count), 32'd0);

        // N=4, T=128: 64+64+0+1 = 129 -> bit 1
        cfg_n = 4; cfg_t = 128;
        cycle(1, 64, 1); cycle(1, 64, 1); cycle(1, 0, 1); cycle(1, 1, 1);
        cycle(0, 0, 0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_sum",   32'(bus.out_sum),   32'd129);
        chk("t1_bit",   32'(bus.out_bit),   32'd1);
        cycle(0, 0, 1);

        // T=130 -> 0; T=129 -> 1 (equality)
        cfg_t = 130;
        cycle(1, 64, 1); cycle(1, 64, 1); cycle(1, 0, 1); cycle(1, 1, 1);
        cycle(0, 0, 0);
        chk("t2a_bit", 32'(bus.out_bit), 32'd0);
        cfg_t = 129;
        cycle(1, 64, 1); cycle(1, 64, 1); cycle(1, 0, 1); cycle(1, 1, 1);
        cycle(0, 0, 0);
        chk("t2b_sum", 32'(bus.out_sum), 32'd129);
        chk("t2b_bit", 32'(bus.out_bit), 32'd1);
        cycle(0, 0, 1);

        // N=1, five back-to-back neurons of 33, T=32
        do_reset();
        cfg_n = 1; cfg_t = 32;
        for (int i = 0; i < 5; i++) cycle(1, 33, 1);
        cycle(0, 0, 1);
        chk("t3_count", 32'(bus.neuron_count), 32'd5);
        chk("t3_sum",   32'(bus.out_sum),      32'd33);

        // N=2, consumer stalls: in_ready low and result frozen, then hand-off + accept together
        cfg_n = 2; cfg_t = 10;
        cycle(1, 7, 0); cycle(1, 8, 0);
        cycle(1, 3, 0); cycle(1, 3, 0); cycle(1, 3, 0);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_sum",      32'(bus.out_sum),  32'd15);
        cycle(1, 20, 1);
        cycle(1, 21, 1);
        cycle(0, 0, 0);
        chk("t4_sum2", 32'(bus.out_sum), 32'd41);
        cycle(0, 0, 1);

        // N=3, reset after two beats discards the partial neuron
        cfg_n = 3; cfg_t = 0;
        cycle(1, 50, 1); cycle(1, 50, 1);
        do_reset();
        cycle(0, 0, 1);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        cycle(1, 10, 1); cycle(1, 10, 1); cycle(1, 10, 1);
        cycle(0, 0, 0);
        chk("t5_sum", 32'(bus.out_sum), 32'd30);
        cycle(0, 0, 1);

        // cfg_num_words=0 acts as 1; a mid-neuron change 3->5 is ignored
        cfg_n = 0; cfg_t = 4;
        cycle(1, 4, 1);
        cycle(0, 0, 0);
        chk("t6_n0_valid", 32'(bus.out_valid), 32'd1);
        cycle(0, 0, 1);
        cfg_n = 3;
        cycle(1, 1, 1);
        cfg_n = 5;
        cycle(1, 2, 1); cycle(1, 3, 1);
        cycle(0, 0, 0);
        chk("t6_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_sum",   32'(bus.out_sum),   32'd6);
        cycle(0, 0, 1);

        // Randomized traffic with random config, including clamped sizes
        for (int i = 0; i < 600; i++) begin
            cfg_n = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 70))
                                                 : int'($urandom_range(0, 6));
            cfg_t = int'($urandom_range(0, 400));
            cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 64)),
                  bit'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
